// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared definitions for the IF->ID fetch queue slice.
//   ZERO_WORD  : value driven on pc outputs when nothing valid is presented
//   INST_NONE  : canonical NOP (addi x0,x0,0) presented when the queue is empty
//   RST_ENABLE : level of rst that holds the block in reset (active-low)
package fetch_queue_pkg;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] INST_NONE  = 32'h0000_0013;
  localparam logic        RST_ENABLE = 1'b0;

endpackage

// File: rtl/fetch_queue_ptr.sv
// fetch_queue_ptr
//   Wrapping pointer counter used for the read and write sides of the queue.
//   The pointer is W bits wide and wraps modulo 2**W through natural overflow.
//   Ports:
//     clk   in   1  clock, rising edge
//     rst   in   1  reset, asynchronous, active-low
//     clr   in   1  synchronous clear (branch flush), wins over inc
//     inc   in   1  advance pointer by one
//     ptr_o out  W  current pointer value
module fetch_queue_ptr
  import fetch_queue_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr_o
);

  // Pointer register: async reset, then sync clear, then increment.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      ptr_o <= '0;
    end else if (clr) begin
      ptr_o <= '0;
    end else if (inc) begin
      ptr_o <= ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Parametrised IF->ID decoupling queue holding up to DEPTH {pc, inst} pairs,
//   with valid/ready handshakes on both sides and a one-cycle branch flush.
//   Optional performance counters are built when BITTY_IFQ_PERF_EN is defined.
//   Ports:
//     clk          in   1               clock, rising edge
//     rst          in   1               reset, asynchronous, active-low
//     in_valid     in   1               fetch offers {in_pc, in_inst}
//     in_ready     out  1               queue accepts (not full)
//     in_pc        in   ADDR_W          fetched pc
//     in_inst      in   INST_W          fetched instruction
//     flush_i      in   1               branch taken in EX; discard everything
//     out_valid    out  1               head entry valid
//     out_ready    in   1               decoder consumes head
//     out_pc       out  ADDR_W          head pc, 0 when empty
//     out_inst     out  INST_W          head inst, NOP_INST when empty
//     count_o      out  $clog2(DEPTH)+1 occupancy
//     flush_cnt_o  out  32              (BITTY_IFQ_PERF_EN) flushes of a non-empty queue
//     full_cnt_o   out  32              (BITTY_IFQ_PERF_EN) cycles offered while full
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(INST_NONE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  input  logic                       flush_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     count_o
`ifdef BITTY_IFQ_PERF_EN
  ,
  output logic [31:0]                flush_cnt_o,
  output logic [31:0]                full_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + INST_W;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Handshake decode; everything here comes from registered occupancy, so
  // there is no combinational path from the fetch side to the decode side.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count_o   = count_q;

  assign head     = mem[rd_ptr];
  assign out_pc   = out_valid ? head[EW-1:INST_W] : ADDR_W'(ZERO_WORD);
  assign out_inst = out_valid ? head[INST_W-1:0]  : NOP_INST;

  fetch_queue_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_i),
    .inc   (push),
    .ptr_o (wr_ptr)
  );

  fetch_queue_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_i),
    .inc   (pop),
    .ptr_o (rd_ptr)
  );

  // Storage has no reset: an entry is only ever read once count says it
  // was written. A flushed push is not written, so it can never leak out.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= {in_pc, in_inst};
    end
  end

  // Occupancy: flush empties the queue and overrides any same-cycle
  // push or pop; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef BITTY_IFQ_PERF_EN
  // Saturating event counters, cleared only by reset. A flush counts only
  // when it actually discards something; a full stall counts whenever fetch
  // is offering while the queue is full.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      flush_cnt_o <= '0;
      full_cnt_o  <= '0;
    end else begin
      if (flush_i && out_valid && (flush_cnt_o != 32'hFFFF_FFFF)) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
      if (in_valid && !in_ready && (full_cnt_o != 32'hFFFF_FFFF)) begin
        full_cnt_o <= full_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
